// File: rtl/conv33_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : conv33_window_gen
//  Description : Raster-order pixel stream to 3x3 sliding-window generator.
//                Two line buffers hold the previous image rows; every fully
//                interior 3x3 window (stride 1, no padding) is presented on a
//                single-stage valid/ready output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv33_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid_in,
    output logic                  pix_ready_out,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  win_valid_out,
    input  logic                  win_ready_in,
    output logic [DATA_WIDTH-1:0] win_0_0,
    output logic [DATA_WIDTH-1:0] win_0_1,
    output logic [DATA_WIDTH-1:0] win_0_2,
    output logic [DATA_WIDTH-1:0] win_1_0,
    output logic [DATA_WIDTH-1:0] win_1_1,
    output logic [DATA_WIDTH-1:0] win_1_2,
    output logic [DATA_WIDTH-1:0] win_2_0,
    output logic [DATA_WIDTH-1:0] win_2_1,
    output logic [DATA_WIDTH-1:0] win_2_2,
    output logic                  frame_done
);

    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = $clog2(IMG_H);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

    // Raster position of the next pixel to be accepted
    logic [c_COL_W-1:0]    r_col;
    logic [c_ROW_W-1:0]    r_row;

    // lb0 holds row r-1, lb1 holds row r-2 (contents never reset)
    logic [DATA_WIDTH-1:0] r_lb0 [IMG_W];
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_W];

    // Internal shift window and the registered output window, [row][col]
    logic [DATA_WIDTH-1:0] r_win [3][3];
    logic [DATA_WIDTH-1:0] w_shift [3][3];
    logic [DATA_WIDTH-1:0] r_out [3][3];
    logic                  r_win_valid;
    logic                  r_frame_done;

    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_interior;
    logic [DATA_WIDTH-1:0] w_lb0_rd;
    logic [DATA_WIDTH-1:0] w_lb1_rd;

    assign pix_ready_out = !r_win_valid || win_ready_in;
    assign w_accept      = pix_valid_in && pix_ready_out;
    assign w_xfer        = r_win_valid && win_ready_in;
    assign w_col_last    = (r_col == c_COL_LAST);
    assign w_row_last    = (r_row == c_ROW_LAST);
    assign w_interior    = (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);
    assign w_lb0_rd      = r_lb0[r_col];
    assign w_lb1_rd      = r_lb1[r_col];

    // Window after shifting left and inserting the new right-hand column
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                w_shift[i][j] = r_win[i][j+1];
            end
        end
        w_shift[0][2] = w_lb1_rd;
        w_shift[1][2] = w_lb0_rd;
        w_shift[2][2] = pix_data;
    end

    // Column/row raster counters, wrapping at end of line and end of frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line buffers age one row per accept at the current column
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= w_lb0_rd;
            r_lb0[r_col] <= pix_data;
        end
    end

    // Internal shift window advances on every accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= w_shift[i][j];
                end
            end
        end
    end

    // Output stage: load on interior accept, else clear on transfer, else hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_out[i][j] <= '0;
                end
            end
        end else if (w_accept && w_interior) begin
            r_win_valid <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_out[i][j] <= w_shift[i][j];
                end
            end
        end else if (w_xfer) begin
            r_win_valid <= 1'b0;
        end
    end

    // One-cycle pulse after the last pixel of the frame is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_col_last && w_row_last;
        end
    end

    assign win_valid_out = r_win_valid;
    assign frame_done    = r_frame_done;
    assign win_0_0       = r_out[0][0];
    assign win_0_1       = r_out[0][1];
    assign win_0_2       = r_out[0][2];
    assign win_1_0       = r_out[1][0];
    assign win_1_1       = r_out[1][1];
    assign win_1_2       = r_out[1][2];
    assign win_2_0       = r_out[2][0];
    assign win_2_1       = r_out[2][1];
    assign win_2_2       = r_out[2][2];

endmodule
`default_nettype wire

// File: doc/conv33_window_gen.md
Name: conv33_window_gen

Overview:
- Producer side of the conv33 3x3-window data interface.
- Accepts a raster-order pixel stream (one pixel per handshake).
- Holds the two previous image rows in line buffers and emits every fully-interior 3x3 window (stride 1, no padding) with a valid/ready handshake.
- Sits between the feature-map source and the conv33 data inputs; its window ports map 1:1 onto data_in_i_j.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_W, 28, image width in pixels; legal range is 3 or more.
- IMG_H, 28, image height in pixels; legal range is 3 or more.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pix_valid_in  input  1  pix_data is valid.
- pix_ready_out  output  1  block can accept a pixel this cycle.
- pix_data  input  DATA_WIDTH  pixel, raster order (row-major, column 0 first).
- win_valid_out  output  1  window outputs hold a valid window.
- win_ready_in  input  1  consumer accepts the window.
- win_0_0 .. win_2_2  output  DATA_WIDTH each (9 ports)  window; i = row (0 = oldest, r-2), j = column (0 = leftmost, c-2).
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - win_valid_out = 0; all win_i_j = 0; frame_done = 0.
  - Column and row counters = 0; 3x3 shift window = 0.
  - Line-buffer RAM contents are not reset.
  - pix_ready_out = 1 after reset.
- Handshakes:
  - An input accept is pix_valid_in & pix_ready_out.
  - An output transfer is win_valid_out & win_ready_in.
  - pix_ready_out = !win_valid_out | win_ready_in (combinational; single output stage, no skid).
- On each input accept of a pixel at (r, c):
  - Shift the internal 3x3 window left by one column.
  - The new right column is rows 0, 1, 2 = lb1[c], lb0[c], pix_data, using pre-update line-buffer values.
  - Then lb1[c] <= lb0[c] and lb0[c] <= pix_data.
  - Advance c. At c = IMG_W-1, c wraps to 0 and r increments. At r = IMG_H-1 and c = IMG_W-1, both return to 0.
- Window emission:
  - If the accepted pixel has r >= 2 and c >= 2, the output register loads the post-shift window on the same edge.
  - win_valid_out = 1 the following cycle. Latency from accept to window visible is 1 cycle.
- Output valid update on each edge, highest priority first:
  - Load: win_valid_out = 1.
  - Else, transfer: win_valid_out = 0.
  - Else: hold.
- Output stability: while win_valid_out = 1 and win_ready_in = 0, win_i_j and win_valid_out hold. No pixel is accepted in that state.
- Window count: each frame yields exactly (IMG_W-2)*(IMG_H-2) windows, in raster order of their bottom-right pixel.
- Edge pixels: pixels with r < 2 or c < 2 update the line buffers and shift window but produce no window.
- Line-buffer contents from a previous frame are never visible in any emitted window.
- Simultaneous events: a transfer and a new accept in the same cycle sustains one window per cycle, with no bubble.
- frame_done is asserted for exactly one cycle on the edge after the accept of pixel (IMG_H-1, IMG_W-1). It is independent of output backpressure.
- Reset mid-frame:
  - The pending window is dropped and counters restart at (0,0).
  - The next accepted pixel is treated as (0,0).
- Counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide. There is no arithmetic on pixel values; data passes through bit-exact.

Test Plan:
1. IMG_W=5, IMG_H=4; stream pix = 5r+c with win_ready_in held 1 and pix_valid_in held 1 -> exactly 6 windows.
   - First window, one cycle after accepting pixel 12: rows {0,1,2},{5,6,7},{10,11,12}.
   - Last window: {7,8,9},{12,13,14},{17,18,19}.
   - frame_done pulses once, on the cycle after accepting pixel 19.
2. Same stream with win_ready_in = 0 for 4 cycles while the first window is valid -> pix_ready_out = 0, window {0,1,2},{5,6,7},{10,11,12} stable, no pixel lost. After release, the remaining 5 windows match the expected values.
3. Random pix_valid_in gaps (about 50%) and random win_ready_in -> window sequence is identical to scenario 1, count = 6.
4. Two back-to-back frames, second frame pix = 100+5r+c -> second frame's first window is {100,101,102},{105,106,107},{110,111,112}; no stale first-frame data appears; frame_done pulses twice.
5. Assert rst after 8 pixels of a frame, then restart the stream from pixel 0 -> after reset all outputs are 0; the full 6-window sequence from scenario 1 follows, with no spurious window.
6. Corner-size check IMG_W=3, IMG_H=3, pix 1..9 -> exactly one window {1,2,3},{4,5,6},{7,8,9}, then frame_done.
